// File: rtl/sd_clock_manager_if.sv
// Host-side handshake between the SD host register bank and sd_clock_manager.
// The register bank drives the master modport; the clock manager uses the slave modport.
interface sd_clock_manager_if;
  logic       DIV_REQ;
  logic [7:0] DIV_VAL;
  logic       DIV_ACK;
  logic       STOP_REQ;
  logic       BUSY;

  modport master (
    output DIV_REQ,
    output DIV_VAL,
    output STOP_REQ,
    output BUSY,
    input  DIV_ACK
  );

  modport slave (
    input  DIV_REQ,
    input  DIV_VAL,
    input  STOP_REQ,
    input  BUSY,
    output DIV_ACK
  );
endinterface

// File: rtl/sd_clock_manager.sv
// SD clock sequencer: power-up clock train, glitch-free divider switching and SD_CLK stop/restart.
// Optional idle auto-stop is enabled by defining SD_CLK_AUTO_STOP_EN.
module sd_clock_manager #(
  parameter logic [7:0]  INIT_DIV    = 8'd62,
  parameter int unsigned INIT_CYCLES = 74
`ifdef SD_CLK_AUTO_STOP_EN
  ,
  parameter int unsigned IDLE_CYCLES = 16
`endif
) (
  input  logic                     CLK,
  input  logic                     RST,
  sd_clock_manager_if.slave        hif,
  input  logic                     SD_CLK_I,
  output logic [7:0]               DIVIDER_O,
  output logic                     CLK_EN_O,
  output logic                     INIT_DONE,
  output logic                     CLK_STOPPED
);

  localparam int unsigned DIV_W      = 8;
  localparam int unsigned INIT_CNT_W = 7;
`ifdef SD_CLK_AUTO_STOP_EN
  localparam int unsigned IDLE_W     = $clog2(IDLE_CYCLES + 1);
`endif

  typedef enum logic [2:0] {
    ST_INIT      = 3'd0,
    ST_RUN       = 3'd1,
    ST_SWITCH    = 3'd2,
    ST_STOP_WAIT = 3'd3,
    ST_STOPPED   = 3'd4
  } state_e;

  state_e                state_q,       state_d;
  logic                  sd_clk_q,      sd_clk_d;
  logic [INIT_CNT_W-1:0] init_cnt_q,    init_cnt_d;
  logic [DIV_W-1:0]      divider_q,     divider_d;
  logic                  clk_en_q,      clk_en_d;
  logic                  div_ack_q,     div_ack_d;
  logic                  init_done_q,   init_done_d;
  logic                  clk_stopped_q, clk_stopped_d;

  logic                  rise_c;
  logic                  fall_c;
  logic                  div_req_c;
  logic                  stop_req_c;
  logic [DIV_W-1:0]      div_sel_c;
  logic [INIT_CNT_W-1:0] init_cnt_inc_c;

  // SD_CLK_I is already CLK-synchronous, so one delay flop gives both edges.
  always_comb begin
    sd_clk_d       = SD_CLK_I;
    rise_c         = SD_CLK_I & ~sd_clk_q;
    fall_c         = ~SD_CLK_I & sd_clk_q;
    init_cnt_inc_c = init_cnt_q + INIT_CNT_W'(1);
    div_sel_c      = (hif.DIV_VAL == DIV_W'(0)) ? DIV_W'(1) : hif.DIV_VAL;
    // The ack cycle masks DIV_REQ so a request still held high is not taken twice.
    div_req_c      = hif.DIV_REQ & ~div_ack_q;
  end

`ifdef SD_CLK_AUTO_STOP_EN
  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              auto_stop_c;

  // Idle rises counted only in RUN; any BUSY clears it, which also withdraws the auto stop.
  always_comb begin
    auto_stop_c = (idle_cnt_q == IDLE_W'(IDLE_CYCLES)) & ~hif.BUSY;
    idle_cnt_d  = idle_cnt_q;
    if (hif.BUSY) begin
      idle_cnt_d = IDLE_W'(0);
    end else if ((state_q == ST_RUN) && rise_c && (idle_cnt_q != IDLE_W'(IDLE_CYCLES))) begin
      idle_cnt_d = idle_cnt_q + IDLE_W'(1);
    end
    stop_req_c = hif.STOP_REQ | auto_stop_c;
  end
`else
  always_comb begin
    stop_req_c = hif.STOP_REQ;
  end
`endif

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    init_cnt_d    = init_cnt_q;
    divider_d     = divider_q;
    clk_en_d      = clk_en_q;
    div_ack_d     = 1'b0;
    init_done_d   = init_done_q;
    clk_stopped_d = clk_stopped_q;

    case (state_q)
      ST_INIT: begin
        if (rise_c) begin
          init_cnt_d = init_cnt_inc_c;
          if (init_cnt_inc_c == INIT_CNT_W'(INIT_CYCLES)) begin
            init_done_d = 1'b1;
            state_d     = ST_RUN;
          end
        end
      end

      ST_RUN: begin
        if (div_req_c) begin
          state_d = ST_SWITCH;
        end else if (stop_req_c) begin
          state_d = ST_STOP_WAIT;
        end
      end

      // Divider counter is at most 1 just after a fall, so the new value never cuts a half-period short.
      ST_SWITCH: begin
        if (!hif.DIV_REQ) begin
          state_d = ST_RUN;
        end else if (fall_c) begin
          divider_d = div_sel_c;
          div_ack_d = 1'b1;
          state_d   = ST_RUN;
        end
      end

      ST_STOP_WAIT: begin
        if (!stop_req_c) begin
          state_d = ST_RUN;
        end else if (fall_c) begin
          clk_en_d      = 1'b0;
          clk_stopped_d = 1'b1;
          state_d       = ST_STOPPED;
        end
      end

      // Gated clock: divider may change immediately; a pending divider change wins over resume.
      ST_STOPPED: begin
        if (div_req_c) begin
          divider_d = div_sel_c;
          div_ack_d = 1'b1;
        end else if (!stop_req_c) begin
          clk_en_d      = 1'b1;
          clk_stopped_d = 1'b0;
          state_d       = ST_RUN;
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= ST_INIT;
      sd_clk_q      <= 1'b0;
      init_cnt_q    <= INIT_CNT_W'(0);
      divider_q     <= INIT_DIV;
      clk_en_q      <= 1'b1;
      div_ack_q     <= 1'b0;
      init_done_q   <= 1'b0;
      clk_stopped_q <= 1'b0;
`ifdef SD_CLK_AUTO_STOP_EN
      idle_cnt_q    <= IDLE_W'(0);
`endif
    end else begin
      state_q       <= state_d;
      sd_clk_q      <= sd_clk_d;
      init_cnt_q    <= init_cnt_d;
      divider_q     <= divider_d;
      clk_en_q      <= clk_en_d;
      div_ack_q     <= div_ack_d;
      init_done_q   <= init_done_d;
      clk_stopped_q <= clk_stopped_d;
`ifdef SD_CLK_AUTO_STOP_EN
      idle_cnt_q    <= idle_cnt_d;
`endif
    end
  end

  assign hif.DIV_ACK = div_ack_q;
  assign DIVIDER_O   = divider_q;
  assign CLK_EN_O    = clk_en_q;
  assign INIT_DONE   = init_done_q;
  assign CLK_STOPPED = clk_stopped_q;

endmodule
